// File: rtl/camera_capture_pkg.sv
// Shared types and constants for the camera capture front end.
// FSM encoding, YUV422 byte phases and the luma nibble slice.
package camera_capture_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SYNC   = 2'd1,
      ACTIVE = 2'd2
   } cap_state_t;

   localparam logic PHASE_Y = 1'b0;
   localparam logic PHASE_C = 1'b1;

   localparam int LUMA_HI = 7;
   localparam int LUMA_LO = 4;

endpackage

// File: rtl/sync_edge_detect.sv
// Single-bit input register with rise/fall detection.
// Edges compare the registered sample against the previous one.
module sync_edge_detect (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q,
   output logic rise,
   output logic fall
);

   logic q_d;

   // capture the input once, keep one cycle of history for edges
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q   <= 1'b0;
         q_d <= 1'b0;
      end else begin
         q   <= d;
         q_d <= q;
      end
   end

   assign rise = q & ~q_d;
   assign fall = ~q & q_d;

endmodule

// File: rtl/camera_capture.sv
// Captures the luma of a YUV422 camera stream into a frame buffer.
// Writes one 4-bit pixel per Y byte, raster addressed from 0.
module camera_capture
   import camera_capture_pkg::*;
#(
   parameter int RESOLUTION_WIDTH  = 640,
   parameter int RESOLUTION_HEIGHT = 480
) (
   input  logic pclk,
   input  logic rst,
   input  logic cam_vsync,
   input  logic cam_href,
   input  logic [7:0] cam_data,
   output logic w_clk,
   output logic [$clog2(RESOLUTION_WIDTH*RESOLUTION_HEIGHT):0] w_addr,
   output logic [3:0] w_data,
   output logic w_en,
   output logic [$clog2(RESOLUTION_WIDTH):0] pixel_x,
   output logic [$clog2(RESOLUTION_HEIGHT):0] pixel_y,
   output logic frame_done,
   output logic line_err
);

   localparam int AW = $clog2(RESOLUTION_WIDTH*RESOLUTION_HEIGHT) + 1;
   localparam int XW = $clog2(RESOLUTION_WIDTH) + 1;
   localparam int YW = $clog2(RESOLUTION_HEIGHT) + 1;

   localparam logic [XW-1:0] W_X  = XW'(RESOLUTION_WIDTH);
   localparam logic [XW-1:0] W_X1 = XW'(RESOLUTION_WIDTH + 1);
   localparam logic [YW-1:0] H_Y  = YW'(RESOLUTION_HEIGHT);
   localparam logic [AW-1:0] W_A  = AW'(RESOLUTION_WIDTH);

   logic vs_q;
   logic vs_rise;
   logic vs_fall;
   logic hr_q;
   logic hr_rise;
   logic hr_fall;
   logic [7:0] data_q;
   logic unused_chroma_bits;

   cap_state_t state;
   logic phase;
   logic [XW-1:0] x_cnt;
   logic [YW-1:0] y_line;
   logic [AW-1:0] line_base;

   logic [XW-1:0] col;
   logic [XW-1:0] x_next;
   logic is_y;
   logic in_bounds;

   assign w_clk = pclk;

   sync_edge_detect u_vsync (
      .clk  (pclk),
      .rst  (rst),
      .d    (cam_vsync),
      .q    (vs_q),
      .rise (vs_rise),
      .fall (vs_fall)
   );

   sync_edge_detect u_href (
      .clk  (pclk),
      .rst  (rst),
      .d    (cam_href),
      .q    (hr_q),
      .rise (hr_rise),
      .fall (hr_fall)
   );

   // data is aligned with the registered href/vsync samples
   always_ff @(posedge pclk or posedge rst) begin
      if (rst) begin
         data_q <= '0;
      end else begin
         data_q <= cam_data;
      end
   end

   assign unused_chroma_bits = ^data_q[LUMA_LO-1:0];

   // first Y byte of a line is column 0 regardless of the old count;
   // count saturates one past the width so long lines stay detectable
   assign col       = hr_rise ? '0 : x_cnt;
   assign x_next    = (col == W_X1) ? col : col + XW'(1);
   assign is_y      = hr_q && (phase == PHASE_Y);
   assign in_bounds = (col < W_X) && (y_line < H_Y);

   // frame sequencing, line bookkeeping and registered write port
   always_ff @(posedge pclk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         phase      <= PHASE_Y;
         x_cnt      <= '0;
         y_line     <= '0;
         line_base  <= '0;
         w_en       <= 1'b0;
         w_data     <= '0;
         w_addr     <= '0;
         pixel_x    <= '0;
         pixel_y    <= '0;
         frame_done <= 1'b0;
         line_err   <= 1'b0;
      end else begin
         w_en       <= 1'b0;
         frame_done <= 1'b0;
         line_err   <= 1'b0;

         if (hr_q) begin
            phase <= (phase == PHASE_Y) ? PHASE_C : PHASE_Y;
         end else begin
            phase <= PHASE_Y;
         end

         unique case (state)
            IDLE: begin
               if (vs_q) begin
                  state <= SYNC;
               end
            end

            SYNC: begin
               if (vs_fall) begin
                  state     <= ACTIVE;
                  w_addr    <= '0;
                  x_cnt     <= '0;
                  y_line    <= '0;
                  line_base <= '0;
               end
            end

            ACTIVE: begin
               if (vs_rise) begin
                  state      <= SYNC;
                  frame_done <= 1'b1;
               end else begin
                  if (is_y) begin
                     x_cnt <= x_next;
                     if (in_bounds) begin
                        w_en    <= 1'b1;
                        w_data  <= data_q[LUMA_HI:LUMA_LO];
                        w_addr  <= line_base + AW'(col);
                        pixel_x <= col;
                        pixel_y <= y_line;
                     end
                  end
                  if (hr_fall) begin
                     if (x_cnt != '0 && y_line != H_Y) begin
                        y_line    <= y_line + YW'(1);
                        line_base <= line_base + W_A;
                     end
                     if (x_cnt != W_X) begin
                        line_err <= 1'b1;
                     end
                  end
               end
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_camera_capture.sv
// Randomized bench for camera_capture against a frame-level model.
// Model lists expected writes per line from line lengths and bounds.
module tb_camera_capture;

   localparam int W  = 4;
   localparam int H  = 2;
   localparam int AW = $clog2(W*H) + 1;
   localparam int XW = $clog2(W) + 1;
   localparam int YW = $clog2(H) + 1;

   logic pclk = 1'b0;
   logic rst;
   logic cam_vsync;
   logic cam_href;
   logic [7:0] cam_data;
   logic w_clk;
   logic [AW-1:0] w_addr;
   logic [3:0] w_data;
   logic w_en;
   logic [XW-1:0] pixel_x;
   logic [YW-1:0] pixel_y;
   logic frame_done;
   logic line_err;

   typedef struct {
      int a;
      int d;
      int x;
      int y;
   } wr_t;

   wr_t act_q[$];
   wr_t exp_q[$];
   int act_err = 0;
   int act_fd  = 0;
   int exp_err = 0;
   int exp_fd  = 0;
   int rst_wen = 0;
   bit m_active = 1'b0;
   int m_line = 0;
   logic [7:0] ybuf [16];

   int n_checks = 0;
   int n_errors = 0;

   always #5 pclk = ~pclk;

   camera_capture #(
      .RESOLUTION_WIDTH  (W),
      .RESOLUTION_HEIGHT (H)
   ) dut (
      .pclk       (pclk),
      .rst        (rst),
      .cam_vsync  (cam_vsync),
      .cam_href   (cam_href),
      .cam_data   (cam_data),
      .w_clk      (w_clk),
      .w_addr     (w_addr),
      .w_data     (w_data),
      .w_en       (w_en),
      .pixel_x    (pixel_x),
      .pixel_y    (pixel_y),
      .frame_done (frame_done),
      .line_err   (line_err)
   );

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // collect everything the DUT writes or flags, away from the edge
   always @(negedge pclk) begin
      if (rst) begin
         if (w_en) rst_wen++;
      end else begin
         if (w_en) begin
            wr_t w;
            w.a = int'(w_addr);
            w.d = int'(w_data);
            w.x = int'(pixel_x);
            w.y = int'(pixel_y);
            act_q.push_back(w);
         end
         if (line_err) act_err++;
         if (frame_done) act_fd++;
      end
   end

   task automatic model_line(input int sent, input bit done);
      if (!m_active) return;
      for (int k = 0; k < sent; k++) begin
         if (m_line < H && k < W) begin
            wr_t w;
            w.a = m_line * W + k;
            w.d = int'(ybuf[k]) / 16;
            w.x = k;
            w.y = m_line;
            exp_q.push_back(w);
         end
      end
      if (done) begin
         if (sent != W) exp_err++;
         if (sent > 0) m_line++;
      end
   endtask

   task automatic model_vsync();
      if (m_active) exp_fd++;
      m_active = 1'b1;
      m_line = 0;
   endtask

   task automatic drive(input logic v, input logic h, input logic [7:0] d);
      @(negedge pclk);
      cam_vsync = v;
      cam_href  = h;
      cam_data  = d;
   endtask

   task automatic vsync_pulse();
      repeat (3) drive(1'b1, 1'b0, 8'h00);
      repeat (2) drive(1'b0, 1'b0, 8'h00);
      model_vsync();
   endtask

   // abort >= 0 raises vsync on that Y slot and ends the frame there
   task automatic send_line(input int n, input int abort, input bit rnd);
      if (rnd) begin
         for (int k = 0; k < n; k++) ybuf[k] = 8'($urandom);
      end
      for (int k = 0; k < n; k++) begin
         if (k == abort) begin
            drive(1'b1, 1'b1, ybuf[k]);
            drive(1'b1, 1'b0, 8'h00);
            drive(1'b1, 1'b0, 8'h00);
            drive(1'b0, 1'b0, 8'h00);
            drive(1'b0, 1'b0, 8'h00);
            model_line(k, 1'b0);
            model_vsync();
            return;
         end
         drive(1'b0, 1'b1, ybuf[k]);
         drive(1'b0, 1'b1, rnd ? 8'($urandom) : 8'h80);
      end
      repeat (3) drive(1'b0, 1'b0, 8'h00);
      model_line(n, 1'b1);
   endtask

   task automatic compare(input string name);
      int n;
      repeat (4) @(negedge pclk);
      @(posedge pclk);
      #1;
      check({name, "_nwr"}, act_q.size(), exp_q.size());
      n = (act_q.size() < exp_q.size()) ? act_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) begin
         check($sformatf("%s_addr%0d", name, i), act_q[i].a, exp_q[i].a);
         check($sformatf("%s_data%0d", name, i), act_q[i].d, exp_q[i].d);
         check($sformatf("%s_x%0d", name, i), act_q[i].x, exp_q[i].x);
         check($sformatf("%s_y%0d", name, i), act_q[i].y, exp_q[i].y);
      end
      check({name, "_line_err"}, act_err, exp_err);
      check({name, "_frame_done"}, act_fd, exp_fd);
      act_q.delete();
      exp_q.delete();
      act_err = 0;
      act_fd  = 0;
      exp_err = 0;
      exp_fd  = 0;
   endtask

   initial begin
      int nl;
      int n;
      int ab;

      rst       = 1'b1;
      cam_vsync = 1'b0;
      cam_href  = 1'b0;
      cam_data  = 8'h00;
      repeat (3) @(negedge pclk);
      #1;
      check("rst_w_en", w_en, 0);
      check("rst_w_addr", w_addr, 0);
      check("rst_w_data", w_data, 0);
      check("rst_pixel_x", pixel_x, 0);
      check("rst_pixel_y", pixel_y, 0);
      check("rst_frame_done", frame_done, 0);
      check("rst_line_err", line_err, 0);
      check("w_clk_follows", w_clk, pclk);
      @(negedge pclk);
      rst = 1'b0;

      // two clean lines with fixed luma 1,2,3,4
      vsync_pulse();
      ybuf[0] = 8'h10;
      ybuf[1] = 8'h20;
      ybuf[2] = 8'h30;
      ybuf[3] = 8'h40;
      send_line(4, -1, 1'b0);
      send_line(4, -1, 1'b0);
      vsync_pulse();
      compare("basic");

      // over-long line is clipped and flagged
      send_line(6, -1, 1'b1);
      send_line(4, -1, 1'b1);
      vsync_pulse();
      compare("long");

      // short line leaves a hole, next line on its own row
      send_line(3, -1, 1'b1);
      send_line(4, -1, 1'b1);
      vsync_pulse();
      compare("short");

      // lines beyond the frame height never write
      repeat (3) send_line(4, -1, 1'b1);
      vsync_pulse();
      compare("extra");

      // vsync arriving inside a line ends the frame silently
      send_line(4, -1, 1'b1);
      send_line(4, 2, 1'b1);
      compare("abort");

      // reset asserted mid-line, released mid-line of a later frame
      for (int k = 0; k < 4; k++) ybuf[k] = 8'($urandom);
      drive(1'b0, 1'b1, ybuf[0]);
      drive(1'b0, 1'b1, 8'h55);
      drive(1'b0, 1'b1, ybuf[1]);
      drive(1'b0, 1'b1, 8'h55);
      @(negedge pclk);
      cam_data = ybuf[2];
      #2;
      rst = 1'b1;
      #1;
      check("async_rst_w_en", w_en, 0);
      check("async_rst_w_addr", w_addr, 0);
      check("async_rst_pixel_x", pixel_x, 0);
      check("async_rst_pixel_y", pixel_y, 0);
      model_line(2, 1'b0);
      m_active = 1'b0;
      for (int k = 0; k < 6; k++) begin
         if (k == 3) begin
            @(negedge pclk);
            rst = 1'b0;
            cam_data = 8'($urandom);
         end else begin
            drive(1'b0, 1'b1, 8'($urandom));
         end
      end
      repeat (3) drive(1'b0, 1'b0, 8'h00);
      send_line(4, -1, 1'b1);
      send_line(4, -1, 1'b1);
      compare("rstmid");
      vsync_pulse();
      send_line(4, -1, 1'b1);
      vsync_pulse();
      compare("rstresume");

      // randomized frames of mixed line lengths
      for (int f = 0; f < 10; f++) begin
         nl = int'($urandom_range(1, 3));
         ab = -1;
         for (int l = 0; l < nl; l++) begin
            n = int'($urandom_range(1, 6));
            ab = -1;
            if (l == nl - 1 && $urandom_range(0, 3) == 0) begin
               ab = int'($urandom_range(0, n - 1));
            end
            send_line(n, ab, 1'b1);
         end
         if (ab < 0) vsync_pulse();
         compare($sformatf("rnd%0d", f));
      end

      check("no_write_in_reset", rst_wen, 0);

      $display("Simulation finished: %0d checks, %0d errors",
               n_checks, n_errors);
      $finish;
   end

endmodule
